hd_pkt_writer: RTL and testbench
================================

Name: hd_pkt_writer

Overview:
- Downstream neighbour of the Hamming-decode stage. It consumes each decoded packet (1024-bit packet image, priority, valid and error flags) and writes it into SRAM as 16 beats of 64 bits in a packet slot it allocates.
- After the last beat it issues a descriptor (slot, priority) to the queue manager.
- It drops packets flagged with error, packets arriving while all slots are used, and packets arriving while busy, and counts each class of drop.

Parameters:
- DATAPACK_BIT, 1024, width of the packet image.
- PRIORITY_BIT, 3, priority width.
- SRAM_DW, 64, SRAM word width; BEATS = DATAPACK_BIT/SRAM_DW = 16.
- SLOT_BIT, 8, slot index width; SLOT_NUM = 2**SLOT_BIT.
- ADDR_W, SLOT_BIT+$clog2(BEATS) = 12, SRAM word address width.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- Queue  in  DATAPACK_BIT  decoded packet image from the decode stage
- prior  in  PRIORITY_BIT  packet priority
- data_vld  in  1  one-cycle pulse: Queue/prior/error are valid
- error  in  1  uncorrectable (2-bit) error in this packet
- in_ready  out  1  high in IDLE (status only; upstream has no backpressure)
- sram_wr_en  out  1  write request
- sram_addr  out  ADDR_W  {slot, beat}
- sram_wdata  out  SRAM_DW  beat data
- sram_ready  in  1  SRAM accepts the current beat this cycle
- desc_vld  out  1  descriptor valid
- desc_slot  out  SLOT_BIT  slot holding the packet
- desc_prior  out  PRIORITY_BIT  packet priority
- desc_rdy  in  1  descriptor accepted
- pkt_release  in  1  one-cycle pulse: the oldest slot has been freed by the reader
- used_cnt  out  SLOT_BIT+1  occupied slots
- drop_err_cnt  out  CNT_W  packets dropped for error
- drop_full_cnt  out  CNT_W  packets dropped because no slot was free
- drop_busy_cnt  out  CNT_W  packets dropped because they arrived while not in IDLE

Behaviour:
- Reset values: all outputs and internal state 0, state=IDLE, wr_slot=0. in_ready=1 once rst_n is high. Reset mid-operation aborts any write and descriptor; no partial descriptor is ever issued.
- FSM states: IDLE, WRITE, DESC.
- IDLE, data_vld=1:
  - error=1: drop_err_cnt++, stay in IDLE.
  - else if used_cnt==SLOT_NUM: drop_full_cnt++, stay in IDLE.
  - else: latch Queue and prior into the buffer, beat=0, go to WRITE.
  - error takes precedence over full.
- WRITE:
  - sram_wr_en=1, sram_addr={wr_slot, beat}, sram_wdata=buf[beat*SRAM_DW +: SRAM_DW] (beat 0 is the LSBs).
  - On sram_ready, beat++. On acceptance of beat BEATS-1, go to DESC.
  - Address and data stay stable while sram_ready=0.
- DESC:
  - desc_vld=1, desc_slot=wr_slot, desc_prior=latched prior; values stay stable until accepted.
  - On desc_rdy: wr_slot++ (wraps SLOT_NUM-1 to 0), used_cnt++, go to IDLE.
- data_vld while in WRITE or DESC: the packet is discarded, drop_busy_cnt++, and the in-flight packet is unaffected.
- pkt_release: used_cnt-- if used_cnt>0; ignored when used_cnt=0. Release coinciding with a desc handshake leaves used_cnt unchanged.
- All drop counters saturate at 2**CNT_W-1.
- Latency with sram_ready and desc_rdy held at 1:
  - data_vld sampled at edge T.
  - Beats write on edges T+1..T+16.
  - desc_vld is high in the cycle after edge T+16 and the handshake completes at edge T+17.
  - in_ready returns to 1 after edge T+17.
  - Back-to-back accepted packets need at least 18 cycles between data_vld pulses.

Decomposition:
- Shared package hd_pkg: DATA_WIDTH, PRIORITY_BIT, DATAPACK_BIT, SRAM_DW, BEATS, a state enum type, and a descriptor struct {slot, prior}.
- One natural sub-module, hd_slot_alloc: wr_slot pointer, used_cnt, full flag, and release/allocate arbitration.
- The FSM and beat mux stay in the top level.

Test Plan:
- Clean packet, Queue[63:0]=64'hA5A5_0000_0000_0001, Queue[1023:960]=64'h1234_5678_9ABC_DEF0, prior=3'd5, sram_ready=1, desc_rdy=1 -> 16 writes to addresses 0x000..0x00F; the first beat carries A5A5..0001 and the last 1234..DEF0; then desc_slot=0, desc_prior=5; used_cnt=1.
- data_vld with error=1 -> no sram_wr_en, drop_err_cnt=1, in_ready stays 1.
- sram_ready toggled 1,0,0,1 repeating -> the address holds during stalls, each beat is written exactly once, and the descriptor arrives after 16 accepts.
- Fill 256 packets with no release, then send a 257th -> drop_full_cnt=1. One pkt_release, then another packet -> it is accepted into slot 0 (wrap) and used_cnt returns to 256.
- data_vld at T+5 during a write -> drop_busy_cnt=1 and the in-flight write data is unchanged. pkt_release coincident with desc handshake -> used_cnt unchanged.
- Assert rst_n=0 at beat 7 of a write -> all outputs 0 and no descriptor; the next packet after reset writes slot 0.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared parameters, FSM state type and descriptor payload for the packet writer.
package hd_pkg;

   localparam int unsigned DATAPACK_BIT = 1024;
   localparam int unsigned DATA_WIDTH   = DATAPACK_BIT;
   localparam int unsigned PRIORITY_BIT = 3;
   localparam int unsigned SRAM_DW      = 64;
   localparam int unsigned BEATS        = DATAPACK_BIT / SRAM_DW;
   localparam int unsigned BEAT_BIT     = $clog2(BEATS);
   localparam int unsigned SLOT_BIT     = 8;
   localparam int unsigned SLOT_NUM     = 2 ** SLOT_BIT;
   localparam int unsigned ADDR_W       = SLOT_BIT + BEAT_BIT;
   localparam int unsigned CNT_W        = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DESC  = 2'd2
   } state_e;

   typedef struct packed {
      logic [SLOT_BIT-1:0]     slot;
      logic [PRIORITY_BIT-1:0] prior;
   } desc_t;

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/hd_slot_alloc.sv
// Packet slot allocator: write pointer, occupancy count and full flag.
module hd_slot_alloc
   import hd_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc,
   input  logic                pkt_release,
   output logic [SLOT_BIT-1:0] wr_slot,
   output logic [SLOT_BIT:0]   used_cnt,
   output logic                full_c
);

   logic [SLOT_BIT-1:0] wr_slot_q, wr_slot_d;
   logic [SLOT_BIT:0]   used_cnt_q, used_cnt_d;
   logic                rel_ok;

   // Allocate advances the pointer; release and allocate in the same cycle cancel.
   always_comb begin
      wr_slot_d  = wr_slot_q;
      used_cnt_d = used_cnt_q;
      rel_ok     = pkt_release && (used_cnt_q != '0);
      if (alloc) begin
         wr_slot_d = wr_slot_q + SLOT_BIT'(1);
      end
      if (alloc && !rel_ok) begin
         used_cnt_d = used_cnt_q + (SLOT_BIT+1)'(1);
      end else if (!alloc && rel_ok) begin
         used_cnt_d = used_cnt_q - (SLOT_BIT+1)'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_slot_q  <= '0;
         used_cnt_q <= '0;
      end else begin
         wr_slot_q  <= wr_slot_d;
         used_cnt_q <= used_cnt_d;
      end
   end

   assign wr_slot  = wr_slot_q;
   assign used_cnt = used_cnt_q;
   assign full_c   = (used_cnt_q == (SLOT_BIT+1)'(SLOT_NUM));

endmodule

// File: rtl/hd_pkt_writer.sv
// Writes decoded packets into SRAM slots beat by beat and hands descriptors to the queue manager.
module hd_pkt_writer
   import hd_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATAPACK_BIT-1:0] Queue,
   input  logic [PRIORITY_BIT-1:0] prior,
   input  logic                    data_vld,
   input  logic                    error,
   output logic                    in_ready,
   output logic                    sram_wr_en,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic [SRAM_DW-1:0]      sram_wdata,
   input  logic                    sram_ready,
   output logic                    desc_vld,
   output logic [SLOT_BIT-1:0]     desc_slot,
   output logic [PRIORITY_BIT-1:0] desc_prior,
   input  logic                    desc_rdy,
   input  logic                    pkt_release,
   output logic [SLOT_BIT:0]       used_cnt,
   output logic [CNT_W-1:0]        drop_err_cnt,
   output logic [CNT_W-1:0]        drop_full_cnt,
   output logic [CNT_W-1:0]        drop_busy_cnt
);

   state_e                  state_q, state_d;
   logic [BEAT_BIT-1:0]     beat_q, beat_d;
   logic [DATAPACK_BIT-1:0] buf_q, buf_d;
   logic [PRIORITY_BIT-1:0] prior_q, prior_d;
   logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]        full_cnt_q, full_cnt_d;
   logic [CNT_W-1:0]        busy_cnt_q, busy_cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [SRAM_DW-1:0]      wdata_q, wdata_d;
   logic                    desc_vld_q, desc_vld_d;
   desc_t                   desc_q, desc_d;
   logic                    in_ready_q, in_ready_d;

   logic                    alloc;
   logic                    full_c;
   logic [SLOT_BIT-1:0]     wr_slot;

   hd_slot_alloc u_slot_alloc (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (alloc),
      .pkt_release (pkt_release),
      .wr_slot     (wr_slot),
      .used_cnt    (used_cnt),
      .full_c      (full_c)
   );

   // Next-state, drop accounting and registered-output values.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      buf_d      = buf_q;
      prior_d    = prior_q;
      err_cnt_d  = err_cnt_q;
      full_cnt_d = full_cnt_q;
      busy_cnt_d = busy_cnt_q;
      alloc      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (data_vld) begin
               if (error) begin
                  err_cnt_d = sat_inc(err_cnt_q);
               end else if (full_c) begin
                  full_cnt_d = sat_inc(full_cnt_q);
               end else begin
                  buf_d   = Queue;
                  prior_d = prior;
                  beat_d  = '0;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (data_vld) begin
               busy_cnt_d = sat_inc(busy_cnt_q);
            end
            if (sram_ready) begin
               if (beat_q == BEAT_BIT'(BEATS - 1)) begin
                  state_d = ST_DESC;
               end else begin
                  beat_d = beat_q + BEAT_BIT'(1);
               end
            end
         end
         ST_DESC: begin
            if (data_vld) begin
               busy_cnt_d = sat_inc(busy_cnt_q);
            end
            if (desc_rdy) begin
               alloc   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are computed from the next state so they are valid right after the edge.
      wr_en_d    = (state_d == ST_WRITE);
      addr_d     = wr_en_d ? {wr_slot, beat_d} : '0;
      wdata_d    = wr_en_d ? buf_d[SRAM_DW*int'(beat_d) +: SRAM_DW] : '0;
      desc_vld_d = (state_d == ST_DESC);
      desc_d     = '0;
      if (desc_vld_d) begin
         desc_d.slot  = wr_slot;
         desc_d.prior = prior_d;
      end
      in_ready_d = (state_d == ST_IDLE);
   end

   // State, packet buffer, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         buf_q      <= '0;
         prior_q    <= '0;
         err_cnt_q  <= '0;
         full_cnt_q <= '0;
         busy_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         desc_vld_q <= 1'b0;
         desc_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         buf_q      <= buf_d;
         prior_q    <= prior_d;
         err_cnt_q  <= err_cnt_d;
         full_cnt_q <= full_cnt_d;
         busy_cnt_q <= busy_cnt_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         desc_vld_q <= desc_vld_d;
         desc_q     <= desc_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign sram_wr_en    = wr_en_q;
   assign sram_addr     = addr_q;
   assign sram_wdata    = wdata_q;
   assign desc_vld      = desc_vld_q;
   assign desc_slot     = desc_q.slot;
   assign desc_prior    = desc_q.prior;
   assign drop_err_cnt  = err_cnt_q;
   assign drop_full_cnt = full_cnt_q;
   assign drop_busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_hd_pkt_writer.sv
// Directed testbench for the packet writer: vector table plus hand-written corner sequences.
module tb_hd_pkt_writer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1023:0] queue;
   logic [2:0]    prior;
   logic          data_vld;
   logic          error;
   logic          in_ready;
   logic          sram_wr_en;
   logic [11:0]   sram_addr;
   logic [63:0]   sram_wdata;
   logic          sram_ready;
   logic          desc_vld;
   logic [7:0]    desc_slot;
   logic [2:0]    desc_prior;
   logic          desc_rdy;
   logic          pkt_release;
   logic [8:0]    used_cnt;
   logic [15:0]   drop_err_cnt;
   logic [15:0]   drop_full_cnt;
   logic [15:0]   drop_busy_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hd_pkt_writer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .Queue         (queue),
      .prior         (prior),
      .data_vld      (data_vld),
      .error         (error),
      .in_ready      (in_ready),
      .sram_wr_en    (sram_wr_en),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_ready    (sram_ready),
      .desc_vld      (desc_vld),
      .desc_slot     (desc_slot),
      .desc_prior    (desc_prior),
      .desc_rdy      (desc_rdy),
      .pkt_release   (pkt_release),
      .used_cnt      (used_cnt),
      .drop_err_cnt  (drop_err_cnt),
      .drop_full_cnt (drop_full_cnt),
      .drop_busy_cnt (drop_busy_cnt)
   );

   typedef struct {
      logic        err;
      logic [2:0]  prior;
      logic [63:0] lo;
      logic [63:0] hi;
      bit          stall;
      bit          accept;
      logic [7:0]  slot;
      logic [8:0]  used;
      logic [15:0] err_cnt;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Beat 0 = lo, beat 15 = hi, middle beats a distinct pattern per beat.
   function automatic logic [1023:0] make_q(input logic [63:0] lo, input logic [63:0] hi);
      logic [1023:0] q;
      q = '0;
      q[63:0] = lo;
      for (int i = 1; i < 15; i++) q[i*64 +: 64] = (64'h0101_0101_0101_0101 * 64'(i)) ^ lo;
      q[1023:960] = hi;
      return q;
   endfunction

   // One-cycle data_vld pulse; called and returns at a negedge.
   task automatic pulse(input logic [1023:0] q, input logic [2:0] pr, input logic er);
      queue    = q;
      prior    = pr;
      error    = er;
      data_vld = 1'b1;
      @(negedge clk);
      data_vld = 1'b0;
      error    = 1'b0;
   endtask

   // Follow an accepted packet through its 16 beats and the descriptor handshake.
   task automatic run_write(input logic [1023:0] q, input logic [2:0] pr, input logic [7:0] slot,
                            input bit stall, input int inj, input bit rel_at_desc, input bit chk_lat);
      int nb     = 0;
      bit done   = 0;
      int desc_c = -1;
      for (int c = 0; c < 200 && !done; c++) begin
         sram_ready  = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         data_vld    = (c == inj);
         if (c == inj) queue = ~q;
         pkt_release = 1'b0;
         if (sram_wr_en) begin
            if (nb < 16) begin
               chk("wr_addr", 64'(sram_addr), 64'({slot, 4'(nb)}));
               chk("wr_data", sram_wdata, q[nb*64 +: 64]);
            end else begin
               chk("extra_beat", 64'(nb), 64'd15);
            end
            if (sram_ready) nb++;
         end
         if (desc_vld) begin
            chk("desc_slot", 64'(desc_slot), 64'(slot));
            chk("desc_prior", 64'(desc_prior), 64'(pr));
            chk("beats_before_desc", 64'(nb), 64'd16);
            desc_c      = c;
            pkt_release = rel_at_desc;
            done        = 1;
         end
         @(negedge clk);
      end
      data_vld    = 1'b0;
      pkt_release = 1'b0;
      sram_ready  = 1'b1;
      if (!done) chk("desc_timeout", 64'd0, 64'd1);
      if (chk_lat) chk("desc_latency", 64'(desc_c), 64'd16);
      chk("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   // After a dropped packet: no write, no descriptor, in_ready held high.
   task automatic observe_drop(input int n);
      bit saw = 0;
      bit bsy = !in_ready;
      for (int c = 0; c < n; c++) begin
         if (sram_wr_en || desc_vld) saw = 1;
         if (!in_ready) bsy = 1;
         @(negedge clk);
      end
      chk("no_write_on_drop", 64'(saw), 64'd0);
      chk("in_ready_held", 64'(bsy), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t          vecs[5];
      logic [1023:0] q;
      bit            saw;

      vecs[0] = '{1'b0, 3'd5, 64'hA5A5_0000_0000_0001, 64'h1234_5678_9ABC_DEF0, 0, 1, 8'd0, 9'd1, 16'd0};
      vecs[1] = '{1'b1, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 0, 0, 8'd0, 9'd1, 16'd1};
      vecs[2] = '{1'b0, 3'd2, 64'h0F0F_F0F0_1234_4321, 64'hCAFE_BABE_5555_AAAA, 1, 1, 8'd1, 9'd2, 16'd1};
      vecs[3] = '{1'b1, 3'd7, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 0, 8'd0, 9'd2, 16'd2};
      vecs[4] = '{1'b0, 3'd0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 0, 1, 8'd2, 9'd3, 16'd2};

      rst_n       = 1'b0;
      queue       = '0;
      prior       = '0;
      data_vld    = 1'b0;
      error       = 1'b0;
      sram_ready  = 1'b1;
      desc_rdy    = 1'b1;
      pkt_release = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wr_en", 64'(sram_wr_en), 64'd0);
      chk("rst_desc_vld", 64'(desc_vld), 64'd0);
      chk("rst_used", 64'(used_cnt), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Table-driven packets: clean, error, stalled, error, clean.
      foreach (vecs[i]) begin
         q = make_q(vecs[i].lo, vecs[i].hi);
         pulse(q, vecs[i].prior, vecs[i].err);
         if (vecs[i].accept) run_write(q, vecs[i].prior, vecs[i].slot, vecs[i].stall, -1, 1'b0, !vecs[i].stall);
         else                observe_drop(20);
         chk("vec_used", 64'(used_cnt), 64'(vecs[i].used));
         chk("vec_err_cnt", 64'(drop_err_cnt), 64'(vecs[i].err_cnt));
      end

      // Busy drop: data_vld sampled at T+5 during the write.
      q = make_q(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
      pulse(q, 3'd6, 1'b0);
      run_write(q, 3'd6, 8'd3, 1'b0, 4, 1'b0, 1'b1);
      chk("busy_cnt", 64'(drop_busy_cnt), 64'd1);
      chk("busy_used", 64'(used_cnt), 64'd4);

      // Release coincident with the descriptor handshake.
      q = make_q(64'h2222_0000_0000_2222, 64'h3333_0000_0000_3333);
      pulse(q, 3'd1, 1'b0);
      run_write(q, 3'd1, 8'd4, 1'b0, -1, 1'b1, 1'b0);
      chk("rel_at_desc_used", 64'(used_cnt), 64'd4);

      // Plain release.
      pkt_release = 1'b1;
      @(negedge clk);
      pkt_release = 1'b0;
      chk("release_used", 64'(used_cnt), 64'd3);

      // Reset during beat 7 of a write.
      q = make_q(64'h7777_7777_7777_7777, 64'h9999_9999_9999_9999);
      pulse(q, 3'd3, 1'b0);
      saw = 0;
      for (int c = 0; c < 40 && !saw; c++) begin
         if (sram_wr_en && sram_addr[3:0] == 4'd7) saw = 1;
         else @(negedge clk);
      end
      chk("reached_beat7", 64'(saw), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", 64'(sram_wr_en), 64'd0);
      chk("mid_rst_addr", 64'(sram_addr), 64'd0);
      chk("mid_rst_wdata", sram_wdata, 64'd0);
      chk("mid_rst_desc", 64'({desc_vld, desc_slot, desc_prior}), 64'd0);
      chk("mid_rst_cnts", 64'({used_cnt, drop_err_cnt, drop_busy_cnt}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (desc_vld || sram_wr_en) saw = 1;
      end
      chk("no_desc_after_rst", 64'(saw), 64'd0);
      q = make_q(64'hAAAA_0000_BBBB_0000, 64'hCCCC_0000_DDDD_0000);
      pulse(q, 3'd2, 1'b0);
      run_write(q, 3'd2, 8'd0, 1'b0, -1, 1'b0, 1'b1);
      chk("post_rst_used", 64'(used_cnt), 64'd1);

      // Fill the remaining 255 slots.
      for (int k = 1; k < 256; k++) begin
         q = make_q(64'hF000_0000_0000_0000 | 64'(k), ~64'(k));
         pulse(q, 3'(k), 1'b0);
         run_write(q, 3'(k), 8'(k), 1'b0, -1, 1'b0, 1'b0);
      end
      chk("fill_used", 64'(used_cnt), 64'd256);

      // 257th packet is dropped as full.
      q = make_q(64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5);
      pulse(q, 3'd4, 1'b0);
      observe_drop(20);
      chk("full_cnt", 64'(drop_full_cnt), 64'd1);
      chk("full_used", 64'(used_cnt), 64'd256);

      // Free one slot, then the next packet wraps to slot 0.
      pkt_release = 1'b1;
      @(negedge clk);
      pkt_release = 1'b0;
      chk("full_release_used", 64'(used_cnt), 64'd255);
      pulse(q, 3'd4, 1'b0);
      run_write(q, 3'd4, 8'd0, 1'b0, -1, 1'b0, 1'b1);
      chk("wrap_used", 64'(used_cnt), 64'd256);
      chk("wrap_full_cnt", 64'(drop_full_cnt), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
